// File: rtl/wav_recorder_pkg.sv
// Shared types and helpers for wav_recorder: FSM state encoding and the
// RIFF/WAVE header byte generator used when WAV_RECORDER_HEADER_EN is defined.
package wav_recorder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HDR,
    ST_DONE
  } state_t;

  localparam int HDR_BYTES = 44;

  // Byte idx of the canonical 44-byte PCM header. The header is eleven
  // little-endian 32-bit words; the 16-bit fields pair up into words 5 and 8.
  function automatic logic [7:0] hdr_byte(input logic [5:0]  idx,
                                          input logic [31:0] len,
                                          input logic [31:0] rate);
    logic [31:0] w;
    case (idx[5:2])
      4'd0:    w = 32'h4646_4952;          // "RIFF"
      4'd1:    w = len + 32'd36;           // RIFF chunk size
      4'd2:    w = 32'h4556_4157;          // "WAVE"
      4'd3:    w = 32'h2074_6d66;          // "fmt "
      4'd4:    w = 32'd16;                 // fmt chunk size
      4'd5:    w = 32'h0001_0001;          // PCM format 1, 1 channel
      4'd6:    w = rate;                   // sample rate
      4'd7:    w = rate << 1;              // byte rate
      4'd8:    w = 32'h0010_0002;          // block align 2, 16 bits
      4'd9:    w = 32'h6174_6164;          // "data"
      4'd10:   w = len;                    // data chunk size
      default: w = 32'h0000_0000;
    endcase
    return w[{idx[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO for wav_recorder. Show-ahead read: dout is the
// head entry whenever empty is low. clr empties it in one cycle.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Pointer control; the extra MSB tells full from empty.
  always_ff @(posedge clk_sys) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, data only, never reset.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/wav_recorder.sv
// wav_recorder: captures the signed 16-bit mono sample stream into DDR as
// little-endian PCM bytes through the ddram byte-write port.
// Optional feature macro: WAV_RECORDER_HEADER_EN -- PCM starts at BASE_ADDR+44
// and a RIFF/WAVE header is written at BASE_ADDR after the drain.
module wav_recorder
  import wav_recorder_pkg::*;
#(
  parameter logic [27:0] BASE_ADDR   = 28'h0000000,
  parameter logic [27:0] MAX_BYTES   = 28'h0100000,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          SAMPLE_RATE = 48000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic signed [15:0] i_sample,
  input  logic               i_sample_stb,
  input  logic               i_start,
  input  logic               i_stop,
  output logic [27:0]        o_mem_addr,
  output logic [7:0]         o_mem_din,
  output logic               o_mem_we,
  input  logic               i_mem_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [27:0]        o_byte_count
);

`ifdef WAV_RECORDER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [27:0] DATA_BASE = HDR_EN ? BASE_ADDR + 28'(HDR_BYTES) : BASE_ADDR;
  localparam logic [31:0] RATE      = 32'(SAMPLE_RATE);

  state_t             state, state_n;
  logic               fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic signed [15:0] fifo_dout;
  logic [27:0]        queued_bytes;   // committed + queued bytes this recording
  logic               lane_hi;        // next PCM byte is the high byte
  logic               saw_low;        // ready dropped since the last we
  logic [1:0]         hi_cnt;         // ready-high cycles since the last we
  logic [5:0]         hdr_idx;
  logic               start_go, cap_reached, can_issue;
  logic               pcm_issue, hdr_issue, pcm_done;

  assign start_go    = i_start && !i_stop && (state == ST_IDLE || state == ST_DONE);
  assign cap_reached = (queued_bytes >= MAX_BYTES);
  assign fifo_clr    = start_go;
  assign fifo_push   = (state == ST_RUN) && i_sample_stb && !fifo_full && !cap_reached;
  // ddram ready lags our we: only trust it after a fall/re-rise or 2 high cycles.
  assign can_issue   = i_mem_ready && !o_mem_we && (saw_low || hi_cnt == 2'd2);
  assign pcm_issue   = can_issue && !fifo_empty && (state == ST_RUN || state == ST_DRAIN);
  assign hdr_issue   = HDR_EN && can_issue && (state == ST_HDR);
  assign fifo_pop    = pcm_issue && lane_hi;
  assign pcm_done    = fifo_empty && !lane_hi;

  assign o_busy = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_HDR);
  assign o_done = (state == ST_DONE);

  sample_fifo #(
    .DATA_W (16),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clr     (fifo_clr),
    .push    (fifo_push),
    .din     (i_sample),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // FSM next-state; a same-cycle start+stop leaves IDLE/DONE untouched.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_go) state_n = ST_RUN;
      ST_RUN:   if (i_stop || cap_reached) state_n = ST_DRAIN;
      ST_DRAIN: if (pcm_done) state_n = HDR_EN ? ST_HDR : ST_DONE;
      ST_HDR:   if (hdr_issue && hdr_idx == 6'(HDR_BYTES - 1)) state_n = ST_DONE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Write handshake tracker: re-arms once ready falls or stays high 2 cycles.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      saw_low <= 1'b1;
      hi_cnt  <= 2'd0;
    end else if (pcm_issue || hdr_issue) begin
      saw_low <= 1'b0;
      hi_cnt  <= 2'd0;
    end else if (!i_mem_ready) begin
      saw_low <= 1'b1;
    end else if (hi_cnt != 2'd2) begin
      hi_cnt  <= hi_cnt + 2'd1;
    end
  end

  // Byte-lane sequencer, DDR write port and recording counters.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_mem_we     <= 1'b0;
      o_mem_addr   <= BASE_ADDR;
      o_mem_din    <= 8'h00;
      o_byte_count <= '0;
      o_overflow   <= 1'b0;
      queued_bytes <= '0;
      lane_hi      <= 1'b0;
      hdr_idx      <= '0;
    end else begin
      o_mem_we <= pcm_issue || hdr_issue;
      if (start_go) begin
        o_byte_count <= '0;
        o_overflow   <= 1'b0;
        queued_bytes <= '0;
        lane_hi      <= 1'b0;
        hdr_idx      <= '0;
      end else begin
        if (fifo_push) queued_bytes <= queued_bytes + 28'd2;
        if ((state == ST_RUN) && i_sample_stb && fifo_full && !cap_reached)
          o_overflow <= 1'b1;
        if (pcm_issue) begin
          o_mem_addr <= DATA_BASE + o_byte_count;
          o_mem_din  <= lane_hi ? fifo_dout[15:8] : fifo_dout[7:0];
          lane_hi    <= !lane_hi;
          if (o_byte_count < MAX_BYTES) o_byte_count <= o_byte_count + 28'd1;
        end
        if (hdr_issue) begin
          o_mem_addr <= BASE_ADDR + {22'd0, hdr_idx};
          o_mem_din  <= hdr_byte(hdr_idx, {4'd0, o_byte_count}, RATE);
          hdr_idx    <= hdr_idx + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wav_recorder.sv
// Bench for wav_recorder: two instances (FIFO_DEPTH=4 with large capacity,
// and MAX_BYTES=6) share the stimulus; each has its own ddram model whose
// ready drops after every write and returns 1..20 cycles later.
module tb_wav_recorder;

`ifdef WAV_RECORDER_HEADER_EN
  localparam int HDR = 44;
`else
  localparam int HDR = 0;
`endif
  localparam int BASE_A = 0;
  localparam int BASE_B = 64;
  localparam int MAX_A  = 256;
  localparam int MAX_B  = 6;
  localparam int RATE   = 48000;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] sample;
  logic               stb, start, stop;

  logic [27:0] addr_a, cnt_a, addr_b, cnt_b;
  logic [7:0]  din_a, din_b;
  logic        we_a, rdy_a, busy_a, done_a, ovf_a;
  logic        we_b, rdy_b, busy_b, done_b, ovf_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wav_recorder #(.BASE_ADDR(28'(BASE_A)), .MAX_BYTES(28'(MAX_A)), .FIFO_DEPTH(4), .SAMPLE_RATE(RATE)) dut_a (
    .clk_sys(clk), .reset(reset), .i_sample(sample), .i_sample_stb(stb), .i_start(start), .i_stop(stop),
    .o_mem_addr(addr_a), .o_mem_din(din_a), .o_mem_we(we_a), .i_mem_ready(rdy_a),
    .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a), .o_byte_count(cnt_a));

  wav_recorder #(.BASE_ADDR(28'(BASE_B)), .MAX_BYTES(28'(MAX_B)), .FIFO_DEPTH(16), .SAMPLE_RATE(RATE)) dut_b (
    .clk_sys(clk), .reset(reset), .i_sample(sample), .i_sample_stb(stb), .i_start(start), .i_stop(stop),
    .o_mem_addr(addr_b), .o_mem_din(din_b), .o_mem_we(we_b), .i_mem_ready(rdy_b),
    .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b), .o_byte_count(cnt_b));

  // ddram models: memory tagged with the recording that wrote each byte
  int          rec_id = 1;
  logic        hold_a = 1'b0;
  logic        rdy_a_m, rdy_b_m, prev_we_a, prev_we_b, prev_rdy_a, prev_rdy_b;
  int          lat_a, lat_b;
  int          wr_a = 0, wr_b = 0, perr_a = 0, perr_b = 0;
  logic [7:0]  mem_a [512];
  logic [7:0]  mem_b [512];
  int          gen_a [512];
  int          gen_b [512];

  assign rdy_a = rdy_a_m && !hold_a;
  assign rdy_b = rdy_b_m;

  always @(posedge clk) begin
    if (reset) begin
      rdy_a_m <= 1'b1;
      lat_a   <= 0;
    end else if (we_a) begin
      rdy_a_m <= 1'b0;
      lat_a   <= int'($urandom_range(1, 20));
    end else if (!rdy_a_m) begin
      if (lat_a <= 1) rdy_a_m <= 1'b1;
      else            lat_a <= lat_a - 1;
    end
    prev_we_a  <= we_a;
    prev_rdy_a <= rdy_a;
    if (we_a) begin
      mem_a[addr_a[8:0]] <= din_a;
      gen_a[addr_a[8:0]] <= rec_id;
      wr_a <= wr_a + 1;
      if (prev_we_a || !prev_rdy_a || addr_a >= 28'(BASE_A + HDR + MAX_A)) perr_a <= perr_a + 1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      rdy_b_m <= 1'b1;
      lat_b   <= 0;
    end else if (we_b) begin
      rdy_b_m <= 1'b0;
      lat_b   <= int'($urandom_range(1, 20));
    end else if (!rdy_b_m) begin
      if (lat_b <= 1) rdy_b_m <= 1'b1;
      else            lat_b <= lat_b - 1;
    end
    prev_we_b  <= we_b;
    prev_rdy_b <= rdy_b;
    if (we_b) begin
      mem_b[addr_b[8:0]] <= din_b;
      gen_b[addr_b[8:0]] <= rec_id;
      wr_b <= wr_b + 1;
      if (prev_we_b || !prev_rdy_b || addr_b < 28'(BASE_B) || addr_b >= 28'(BASE_B + HDR + MAX_B))
        perr_b <= perr_b + 1;
    end
  end

  logic [15:0] smp [$];
  int          wr0_a, wr0_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rd(input bit b, input int ad);
    if (b) return (gen_b[ad] == rec_id) ? mem_b[ad] : 8'hxx;
    return (gen_a[ad] == rec_id) ? mem_a[ad] : 8'hxx;
  endfunction

`ifdef WAV_RECORDER_HEADER_EN
  function automatic logic [7:0] hdr_exp(input int idx, input int len);
    logic [7:0] h [44];
    int riff, brate;
    riff  = len + 36;
    brate = RATE * 2;
    h[0]  = 8'h52; h[1]  = 8'h49; h[2]  = 8'h46; h[3]  = 8'h46;
    h[8]  = 8'h57; h[9]  = 8'h41; h[10] = 8'h56; h[11] = 8'h45;
    h[12] = 8'h66; h[13] = 8'h6d; h[14] = 8'h74; h[15] = 8'h20;
    h[20] = 8'd1;  h[21] = 8'd0;  h[22] = 8'd1;  h[23] = 8'd0;
    h[32] = 8'd2;  h[33] = 8'd0;  h[34] = 8'd16; h[35] = 8'd0;
    h[36] = 8'h64; h[37] = 8'h61; h[38] = 8'h74; h[39] = 8'h61;
    for (int k = 0; k < 4; k++) begin
      h[4 + k]  = 8'(riff >> (8 * k));
      h[16 + k] = 8'(16 >> (8 * k));
      h[24 + k] = 8'(RATE >> (8 * k));
      h[28 + k] = 8'(brate >> (8 * k));
      h[40 + k] = 8'(len >> (8 * k));
    end
    return h[idx];
  endfunction
`endif

  task automatic start_rec();
    rec_id++;
    smp.delete();
    wr0_a = wr_a;
    wr0_b = wr_b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] s);
    smp.push_back(s);
    sample = s;
    stb    = 1'b1;
    tick();
    stb    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input bit b, input string tag);
    int k;
    k = 0;
    while (!(b ? done_b : done_a) && k < 3000) begin
      tick();
      k++;
    end
    check({tag, "_done"}, b ? done_b : done_a, 1);
  endtask

  // Expected: first n_acc strobed samples, little-endian, at the data base.
  task automatic verify(input bit b, input string tag, input int n_acc, input bit ovf);
    int base;
    base = (b ? BASE_B : BASE_A) + HDR;
    check({tag, "_count"}, b ? cnt_b : cnt_a, 2 * n_acc);
    check({tag, "_ovf"},   b ? ovf_b : ovf_a, ovf);
    check({tag, "_busy"},  b ? busy_b : busy_a, 0);
    check({tag, "_writes"}, b ? wr_b - wr0_b : wr_a - wr0_a, 2 * n_acc + HDR);
    for (int i = 0; i < n_acc; i++) begin
      check($sformatf("%s_lo%0d", tag, i), rd(b, base + 2 * i),     smp[i][7:0]);
      check($sformatf("%s_hi%0d", tag, i), rd(b, base + 2 * i + 1), smp[i][15:8]);
    end
`ifdef WAV_RECORDER_HEADER_EN
    for (int i = 0; i < 44; i++)
      check($sformatf("%s_hdr%0d", tag, i), rd(b, base - HDR + i), hdr_exp(i, 2 * n_acc));
`endif
  endtask

  function automatic int nb_acc(input int n);
    return (n < MAX_B / 2) ? n : MAX_B / 2;
  endfunction

  initial begin
    int k, snap;
    reset = 1'b1; sample = '0; stb = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    check("rst_we",    we_a,   0);
    check("rst_addr",  addr_a, BASE_A);
    check("rst_din",   din_a,  0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_ovf",   ovf_a,  0);
    check("rst_count", cnt_a,  0);
    check("rst_addr_b", addr_b, BASE_B);
    reset = 1'b0;
    tick();

    // Directed four-sample recording
    start_rec();
    strobe(16'h1234); strobe(16'hABCD); strobe(16'h0001); strobe(16'h8000);
    pulse_stop();
    wait_done(0, "t1a");
    wait_done(1, "t1b");
    verify(0, "t1a", 4, 0);
    verify(1, "t1b", nb_acc(4), 0);

    // Ready held low: depth-4 FIFO keeps the first four, then overflows
    hold_a = 1'b1;
    start_rec();
    for (int i = 0; i < 10; i++) strobe(16'($urandom));
    repeat (90) tick();
    hold_a = 1'b0;
    pulse_stop();
    wait_done(0, "t2a");
    wait_done(1, "t2b");
    verify(0, "t2a", 4, 1);
    verify(1, "t2b", nb_acc(10), 0);

    // Continuous strobes: capacity-limited instance finishes on its own
    start_rec();
    for (int i = 0; i < 12; i++) strobe(16'($urandom));
    wait_done(1, "t3b");
    verify(1, "t3b", nb_acc(12), 0);
    pulse_stop();
    wait_done(0, "t3a");

    // Randomised sparse recordings
    for (int r = 0; r < 3; r++) begin
      start_rec();
      k = int'($urandom_range(5, 12));
      for (int i = 0; i < k; i++) begin
        strobe(16'($urandom));
        repeat (50) tick();
      end
      pulse_stop();
      wait_done(0, $sformatf("r%0da", r));
      wait_done(1, $sformatf("r%0db", r));
      verify(0, $sformatf("r%0da", r), k, 0);
      verify(1, $sformatf("r%0db", r), nb_acc(k), 0);
    end

    // start+stop together in DONE, then in IDLE
    snap = int'(cnt_a);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    check("t5_done_stay", done_a, 1);
    check("t5_cnt_stay",  cnt_a,  snap);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    check("t5_idle_busy", busy_a, 0);
    check("t5_idle_done", done_a, 0);

    // start during RUN does not clear the count
    start_rec();
    strobe(16'($urandom));
    repeat (50) tick();
    strobe(16'($urandom));
    k = 0;
    while (cnt_a != 28'd4 && k < 2000) begin tick(); k++; end
    check("t5_cnt4", cnt_a, 4);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("t5_restart_cnt",  cnt_a,  4);
    check("t5_restart_busy", busy_a, 1);
    pulse_stop();
    wait_done(0, "t5a");
    wait_done(1, "t5b");
    verify(0, "t5a", 2, 0);
    verify(1, "t5b", nb_acc(2), 0);

    // Reset mid-RUN with ready low
    hold_a = 1'b1;
    start_rec();
    strobe(16'h1111); strobe(16'h2222); strobe(16'h3333);
    repeat (5) tick();
    check("t4_busy_pre", busy_a, 1);
    reset = 1'b1;
    tick();
    check("t4_we",    we_a,   0);
    check("t4_addr",  addr_a, BASE_A);
    check("t4_din",   din_a,  0);
    check("t4_busy",  busy_a, 0);
    check("t4_done",  done_a, 0);
    check("t4_ovf",   ovf_a,  0);
    check("t4_count", cnt_a,  0);
    reset  = 1'b0;
    hold_a = 1'b0;
    snap   = wr_a;
    strobe(16'h4444); strobe(16'h5555);
    repeat (60) tick();
    check("t4_no_we",   wr_a - snap, 0);
    check("t4_idle_cnt", cnt_a, 0);

    check("a_protocol", perr_a, 0);
    check("b_protocol", perr_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
